// File: rtl/rv32i_types.sv
// rv32i_types: shared enums for the L1-to-memory cache arbiter
package rv32i_types;
  typedef enum logic [1:0] {IDLE, I_ACT, D_ACT, RECOVER} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one memory line port between I-cache and D-cache
//   i_*   : I-cache read request (held until i_resp), line data back with i_resp
//   d_*   : D-cache fill/writeback request (held until d_resp), line data back with d_resp
//   mem_* : single memory port, op held from hold regs until mem_resp
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  arb_state_t        state_q;
  arb_src_t          last_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant_d, grant_i, act;
  // D wins when it is alone or when I had the previous grant
  assign grant_d = (d_read | d_write) & (~i_read | (last_q == SRC_I));
  assign grant_i = i_read & ~grant_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SRC_D;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (grant_d | grant_i) begin
          state_q <= grant_d ? D_ACT : I_ACT;
          last_q  <= grant_d ? SRC_D : SRC_I;
          addr_q  <= grant_d ? d_addr : i_addr;
          wr_q    <= grant_d & d_write;
          wdata_q <= d_wdata;
        end
        I_ACT, D_ACT: if (mem_resp) state_q <= RECOVER;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign act       = (state_q == I_ACT) | (state_q == D_ACT);
  assign mem_read  = (state_q == I_ACT) | ((state_q == D_ACT) & ~wr_q);
  assign mem_write = (state_q == D_ACT) & wr_q;
  assign mem_addr  = act ? addr_q : '0;
  assign mem_wdata = mem_write ? wdata_q : '0;
  assign i_resp    = (state_q == I_ACT) & mem_resp;
  assign d_resp    = (state_q == D_ACT) & mem_resp;
  assign i_rdata   = i_resp ? mem_rdata : '0;
  assign d_rdata   = d_resp ? mem_rdata : '0;
  // simultaneous fill and writeback from the D-cache is a requester bug; write still wins
  a_d_op_onehot: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule
